tx_stream_arbiter: RTL and testbench
====================================

Name: tx_stream_arbiter

Overview:
- Shares the single SoC UART transmitter between NUM_REQ byte-stream requesters, such as the CPU console port and a debug/trace source.
- Arbitration is round-robin with packet locking. A granted requester keeps the transmitter until it sends a byte flagged last, hits the MAX_BURST limit, or goes quiet for IDLE_TIMEOUT cycles.
- A one-entry registered output stage drives the UART TX byte handshake.

Parameters:
- NUM_REQ, 2: number of requesters (2..8).
- DATA_W, 8: byte width.
- MAX_BURST, 16: maximum bytes per grant before forced release (>=1).
- IDLE_TIMEOUT, 32: consecutive cycles without req_valid_i from the grant holder before forced release (>=1).

Ports:
- clk  in  1  system clock.
- reset_i  in  1  asynchronous, active-low reset.
- req_valid_i  in  NUM_REQ  per-requester byte valid.
- req_data_i  in  NUM_REQ*DATA_W  per-requester byte; requester k occupies bits [k*DATA_W +: DATA_W].
- req_last_i  in  NUM_REQ  byte is the final byte of the packet.
- req_ready_o  out  NUM_REQ  per-requester accept.
- tx_valid_o  out  1  byte available for the UART.
- tx_data_o  out  DATA_W  byte to the UART.
- tx_ready_i  in  1  UART accepts the byte (not busy).
- grant_o  out  NUM_REQ  one-hot current grant holder, or 0 when idle.
- busy_o  out  1  high when state is LOCKED or tx_valid_o=1.

Behaviour:
- Reset (reset_i=0, asynchronous) forces:
  - state IDLE;
  - grant_o=0, tx_valid_o=0, tx_data_o=0;
  - burst_cnt=0, idle_cnt=0;
  - last_grant=NUM_REQ-1, so requester 0 has first priority.
- While reset is active, req_ready_o=0. Reset mid-packet drops the in-flight byte and the grant with no completion.
- State IDLE:
  - req_ready_o=0.
  - If any req_valid_i is high, select the first valid index searching (last_grant+1) mod NUM_REQ upward with wrap.
  - Next cycle: grant_o=onehot(sel), last_grant=sel, burst_cnt=0, idle_cnt=0, state LOCKED.
  - Arbitration costs exactly 1 cycle. No byte transfers in the IDLE cycle.
- State LOCKED, holder g:
  - req_ready_o[g] = ~tx_valid_o | tx_ready_i. All other ready bits are 0.
  - Transfer occurs when req_valid_i[g] & req_ready_o[g]. It loads tx_data_o with requester g's byte, sets tx_valid_o=1, increments burst_cnt and clears idle_cnt.
  - Release to IDLE (grant_o=0 next cycle) on any of:
    - a transfer with req_last_i[g]=1;
    - a transfer when burst_cnt==MAX_BURST-1;
    - no req_valid_i[g] while idle_cnt==IDLE_TIMEOUT-1.
  - With no transfer, idle_cnt increments only when req_valid_i[g]=0. It resets when req_valid_i[g]=1 even if the byte is stalled by tx_ready_i=0, so back-pressure never causes a timeout release.
- Output stage:
  - tx_valid_o clears when tx_valid_o & tx_ready_i with no load in the same cycle.
  - A load and a drain in the same cycle keep tx_valid_o=1 with the new byte, giving full throughput of 1 byte/cycle.
  - tx_data_o holds its value while tx_valid_o=1 and tx_ready_i=0.
- Release and re-arbitration:
  - The byte in the output stage still drains after release.
  - Re-arbitration starts in the IDLE cycle and does not wait for the drain.
- Latency: request to grant is 1 cycle. Accepted byte to tx_valid_o is 1 cycle.
- A requester may change req_data_i only after a transfer.
- Requests from non-holders are ignored (not queued) until the next IDLE.
- Counters: burst_cnt is sized to hold MAX_BURST-1; idle_cnt to hold IDLE_TIMEOUT-1. No wrap is possible because release occurs first.

Test Plan:
1. Reset, then req0 sends 3 bytes 0x41,0x42,0x43 (last on 0x43), with tx_ready_i=1 and NUM_REQ=2 -> grant_o=01 one cycle after valid. tx_data_o shows 0x41,0x42,0x43 on consecutive cycles. grant_o=00 after the last byte. busy_o drops after the 0x43 drain.
2. req0 and req1 both assert a 2-byte packet continuously after reset -> grants alternate 01,10,01. Output order is req0 pkt, req1 pkt, req0 pkt. There is a 1-cycle gap between packets.
3. req1 streams 20 bytes with no last, MAX_BURST=16 -> exactly 16 bytes are accepted. grant_o then releases. req1 is regranted only after req0 is served if req0 is pending.
4. Holder req0 sends 1 byte, then deasserts valid -> release after 32 cycles of idle. With tx_ready_i=0 for 100 cycles and valid held, no release, tx_data_o stable, and req_ready_o[0]=0 while the stage is full.
5. Pulse reset_i low mid-packet, asynchronously between clock edges -> tx_valid_o, grant_o and busy_o go 0 immediately. After release, requester 0 wins the first arbitration.
6. Simultaneous load and drain with tx_ready_i toggling 1,0,1 -> no byte is lost or duplicated. A scoreboard matches 8 bytes in order.

Source files
------------

// File: rtl/tx_stream_arbiter.sv
// tx_stream_arbiter
// Shares one UART transmitter between NUM_REQ byte-stream requesters.
// Round-robin arbitration with packet locking: the holder keeps the
// transmitter until it sends a byte flagged last, reaches MAX_BURST bytes,
// or stays silent for IDLE_TIMEOUT cycles. A one-entry registered stage
// presents the selected byte to the UART with a valid/ready handshake.

module tx_stream_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int DATA_W       = 8,
  parameter int MAX_BURST    = 16,
  parameter int IDLE_TIMEOUT = 32
) (
  input  logic                      clk,
  input  logic                      reset_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]        req_last_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic                      tx_valid_o,
  output logic [DATA_W-1:0]         tx_data_o,
  input  logic                      tx_ready_i,
  output logic [NUM_REQ-1:0]        grant_o,
  output logic                      busy_o
);

  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BURST_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int IDLE_W  = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;

  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_REQ - 1);
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);
  localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'(IDLE_TIMEOUT - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   lastGrant_q, lastGrant_d;
  logic [BURST_W-1:0] burstCnt_q, burstCnt_d;
  logic [IDLE_W-1:0]  idleCnt_q, idleCnt_d;
  logic               txValid_q, txValid_d;
  logic [DATA_W-1:0]  txData_q, txData_d;

  logic               anyValid;
  logic               found;
  logic [IDX_W-1:0]   sel;

  logic               holderValid;
  logic               holderLast;
  logic [DATA_W-1:0]  holderData;
  logic               holderReady;
  logic               transfer;
  logic               burstDone;
  logic               idleDone;
  logic               releaseGrant;

  // Round-robin pick: first valid requester after the previous winner, with wrap
  always_comb begin
    anyValid = |req_valid_i;
    found    = 1'b0;
    sel      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!found && req_valid_i[k] &&
            (k == ((int'(lastGrant_q) + i) % NUM_REQ))) begin
          found = 1'b1;
          sel   = IDX_W'(k);
        end
      end
    end
  end

  // Mux the grant holder's request signals out of the packed buses
  always_comb begin
    holderValid = 1'b0;
    holderLast  = 1'b0;
    holderData  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (lastGrant_q == IDX_W'(k)) begin
        holderValid = req_valid_i[k];
        holderLast  = req_last_i[k];
        holderData  = req_data_i[k*DATA_W +: DATA_W];
      end
    end
  end

  // The output stage can take a byte when empty or when it drains this cycle
  assign holderReady  = ~txValid_q | tx_ready_i;
  assign transfer     = (state_q == LOCKED) & holderValid & holderReady;
  assign burstDone    = transfer & (holderLast | (burstCnt_q == BURST_LAST));
  assign idleDone     = (state_q == LOCKED) & ~holderValid & (idleCnt_q == IDLE_LAST);
  assign releaseGrant = burstDone | idleDone;

  // FSM state register; reset drops any grant in progress
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: one arbitration cycle, then locked until release
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (anyValid) begin
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (releaseGrant) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: only the holder sees ready, and only while locked
  always_comb begin
    req_ready_o = '0;
    if (state_q == LOCKED) begin
      req_ready_o = grant_q & {NUM_REQ{holderReady}};
    end
  end

  // Next values for grant bookkeeping, counters and the output stage
  always_comb begin
    grant_d     = grant_q;
    lastGrant_d = lastGrant_q;
    burstCnt_d  = burstCnt_q;
    idleCnt_d   = idleCnt_q;
    txValid_d   = txValid_q;
    txData_d    = txData_q;

    if (state_q == IDLE) begin
      if (anyValid) begin
        grant_d     = {{(NUM_REQ-1){1'b0}}, 1'b1} << sel;
        lastGrant_d = sel;
        burstCnt_d  = '0;
        idleCnt_d   = '0;
      end
    end else begin
      if (releaseGrant) begin
        grant_d    = '0;
        burstCnt_d = '0;
        idleCnt_d  = '0;
      end else if (transfer) begin
        burstCnt_d = burstCnt_q + BURST_W'(1);
        idleCnt_d  = '0;
      end else if (holderValid) begin
        idleCnt_d = '0;
      end else begin
        idleCnt_d = idleCnt_q + IDLE_W'(1);
      end
    end

    if (transfer) begin
      txValid_d = 1'b1;
      txData_d  = holderData;
    end else if (txValid_q && tx_ready_i) begin
      txValid_d = 1'b0;
    end
  end

  // Datapath registers; requester 0 gets first priority after reset
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      grant_q     <= '0;
      lastGrant_q <= LAST_IDX;
      burstCnt_q  <= '0;
      idleCnt_q   <= '0;
      txValid_q   <= 1'b0;
      txData_q    <= '0;
    end else begin
      grant_q     <= grant_d;
      lastGrant_q <= lastGrant_d;
      burstCnt_q  <= burstCnt_d;
      idleCnt_q   <= idleCnt_d;
      txValid_q   <= txValid_d;
      txData_q    <= txData_d;
    end
  end

  assign grant_o    = grant_q;
  assign tx_valid_o = txValid_q;
  assign tx_data_o  = txData_q;
  assign busy_o     = (state_q == LOCKED) | txValid_q;

endmodule

// File: tb/tb_tx_stream_arbiter.sv
// tb_tx_stream_arbiter
// Directed bench for tx_stream_arbiter with two requesters. Each requester
// replays a small byte list, advancing only when its byte is accepted; a
// monitor collects bytes as the UART side takes them.

module tb_tx_stream_arbiter;

  localparam int NUM_REQ      = 2;
  localparam int DATA_W       = 8;
  localparam int MAX_BURST    = 16;
  localparam int IDLE_TIMEOUT = 32;

  logic                      clk = 1'b0;
  logic                      reset_i;
  logic [NUM_REQ-1:0]        req_valid_i;
  logic [NUM_REQ*DATA_W-1:0] req_data_i;
  logic [NUM_REQ-1:0]        req_last_i;
  logic [NUM_REQ-1:0]        req_ready_o;
  logic                      tx_valid_o;
  logic [DATA_W-1:0]         tx_data_o;
  logic                      tx_ready_i;
  logic [NUM_REQ-1:0]        grant_o;
  logic                      busy_o;

  int vecCount = 0;
  int errCount = 0;

  logic [DATA_W-1:0] seqData [NUM_REQ][32];
  logic              seqLast [NUM_REQ][32];
  int                seqLen  [NUM_REQ];
  int                seqPtr  [NUM_REQ];
  logic [DATA_W-1:0] obsQ [$];

  tx_stream_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .DATA_W       (DATA_W),
    .MAX_BURST    (MAX_BURST),
    .IDLE_TIMEOUT (IDLE_TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset_i     (reset_i),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_last_i  (req_last_i),
    .req_ready_o (req_ready_o),
    .tx_valid_o  (tx_valid_o),
    .tx_data_o   (tx_data_o),
    .tx_ready_i  (tx_ready_i),
    .grant_o     (grant_o),
    .busy_o      (busy_o)
  );

  // Free-running clock, 10 time units per period
  always #5 clk = ~clk;

  // Safety net so the run always ends
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish (errors so far %0d)", errCount);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic clear_seq();
    for (int k = 0; k < NUM_REQ; k++) begin
      seqLen[k] = 0;
      seqPtr[k] = 0;
      for (int j = 0; j < 32; j++) begin
        seqData[k][j] = '0;
        seqLast[k][j] = 1'b0;
      end
    end
    obsQ.delete();
  endtask

  // Present each requester's current byte, or nothing once its list is done
  task automatic drive_inputs();
    for (int k = 0; k < NUM_REQ; k++) begin
      if (seqPtr[k] < seqLen[k]) begin
        req_valid_i[k]                 = 1'b1;
        req_data_i[k*DATA_W +: DATA_W] = seqData[k][seqPtr[k]];
        req_last_i[k]                  = seqLast[k][seqPtr[k]];
      end else begin
        req_valid_i[k]                 = 1'b0;
        req_data_i[k*DATA_W +: DATA_W] = '0;
        req_last_i[k]                  = 1'b0;
      end
    end
  endtask

  // One clock: sample handshakes at the falling edge, update requesters after the rising edge
  task automatic step();
    logic [NUM_REQ-1:0] acc;
    @(negedge clk);
    acc = req_valid_i & req_ready_o;
    if (tx_valid_o === 1'b1 && tx_ready_i === 1'b1) begin
      obsQ.push_back(tx_data_o);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (acc[k]) seqPtr[k]++;
    end
    drive_inputs();
  endtask

  task automatic do_reset();
    reset_i    = 1'b0;
    tx_ready_i = 1'b1;
    clear_seq();
    drive_inputs();
    repeat (2) @(posedge clk);
    #1;
    reset_i = 1'b1;
  endtask

  task automatic test_reset();
    clear_seq();
    tx_ready_i = 1'b1;
    reset_i    = 1'b0;
    seqData[0][0] = 8'hA0; seqLast[0][0] = 1'b1; seqLen[0] = 1;
    seqData[1][0] = 8'hB0; seqLast[1][0] = 1'b1; seqLen[1] = 1;
    drive_inputs();
    repeat (2) @(posedge clk);
    #3;
    vecCount++;
    if (grant_o !== 2'b00 || tx_valid_o !== 1'b0 || tx_data_o !== 8'h00 ||
        busy_o !== 1'b0 || req_ready_o !== 2'b00) begin
      errCount++;
      $display("[TB] FAIL reset_state: grant=%b valid=%b data=%h busy=%b ready=%b, want 00 0 00 0 00",
               grant_o, tx_valid_o, tx_data_o, busy_o, req_ready_o);
    end
    @(posedge clk);
    #1;
    reset_i = 1'b1;
    step();
    vecCount++;
    if (grant_o !== 2'b01) begin
      errCount++;
      $display("[TB] FAIL reset_first_priority: grant=%b want 01", grant_o);
    end
  endtask

  task automatic test_single_packet();
    do_reset();
    seqData[0][0] = 8'h41; seqData[0][1] = 8'h42; seqData[0][2] = 8'h43;
    seqLast[0][2] = 1'b1;  seqLen[0] = 3;
    drive_inputs();
    step();
    vecCount++;
    if (grant_o !== 2'b01 || tx_valid_o !== 1'b0) begin
      errCount++;
      $display("[TB] FAIL pkt_grant: grant=%b valid=%b want 01 0", grant_o, tx_valid_o);
    end
    step();
    vecCount++;
    if (tx_valid_o !== 1'b1 || tx_data_o !== 8'h41) begin
      errCount++;
      $display("[TB] FAIL pkt_byte0: valid=%b data=%h want 1 41", tx_valid_o, tx_data_o);
    end
    step();
    vecCount++;
    if (tx_valid_o !== 1'b1 || tx_data_o !== 8'h42) begin
      errCount++;
      $display("[TB] FAIL pkt_byte1: valid=%b data=%h want 1 42", tx_valid_o, tx_data_o);
    end
    step();
    vecCount++;
    if (tx_data_o !== 8'h43 || grant_o !== 2'b00 || busy_o !== 1'b1) begin
      errCount++;
      $display("[TB] FAIL pkt_last: data=%h grant=%b busy=%b want 43 00 1", tx_data_o, grant_o, busy_o);
    end
    step();
    vecCount++;
    if (tx_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      errCount++;
      $display("[TB] FAIL pkt_drain: valid=%b busy=%b want 0 0", tx_valid_o, busy_o);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] expGrant [12] = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00,
                                  2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00};
    logic [7:0] expBytes [8]  = '{8'h01, 8'h02, 8'h11, 8'h12, 8'h03, 8'h04, 8'h13, 8'h14};
    do_reset();
    for (int j = 0; j < 4; j++) begin
      seqData[0][j] = 8'h01 + 8'(j);
      seqData[1][j] = 8'h11 + 8'(j);
      seqLast[0][j] = (j % 2 == 1);
      seqLast[1][j] = (j % 2 == 1);
    end
    seqLen[0] = 4;
    seqLen[1] = 4;
    drive_inputs();
    for (int c = 0; c < 12; c++) begin
      step();
      vecCount++;
      if (grant_o !== expGrant[c]) begin
        errCount++;
        $display("[TB] FAIL rr_grant[%0d]: grant=%b want %b", c, grant_o, expGrant[c]);
      end
    end
    repeat (3) step();
    vecCount++;
    if (obsQ.size() != 8) begin
      errCount++;
      $display("[TB] FAIL rr_count: bytes=%0d want 8", obsQ.size());
    end
    for (int j = 0; j < 8; j++) begin
      if (j < obsQ.size()) begin
        vecCount++;
        if (obsQ[j] !== expBytes[j]) begin
          errCount++;
          $display("[TB] FAIL rr_order[%0d]: byte=%h want %h", j, obsQ[j], expBytes[j]);
        end
      end
    end
  endtask

  task automatic test_max_burst();
    do_reset();
    for (int j = 0; j < 20; j++) begin
      seqData[1][j] = 8'h80 + 8'(j);
    end
    seqLen[1] = 20;
    seqData[0][0] = 8'h55;
    seqLast[0][0] = 1'b1;
    drive_inputs();
    step();
    vecCount++;
    if (grant_o !== 2'b10) begin
      errCount++;
      $display("[TB] FAIL burst_grant: grant=%b want 10", grant_o);
    end
    repeat (4) step();
    seqLen[0] = 1;
    drive_inputs();
    vecCount++;
    if (req_ready_o[0] !== 1'b0) begin
      errCount++;
      $display("[TB] FAIL burst_nonholder_ready: ready0=%b want 0", req_ready_o[0]);
    end
    repeat (12) step();
    vecCount++;
    if (grant_o !== 2'b00 || seqPtr[1] != 16) begin
      errCount++;
      $display("[TB] FAIL burst_release: grant=%b accepted=%0d want 00 16", grant_o, seqPtr[1]);
    end
    step();
    vecCount++;
    if (grant_o !== 2'b01 || seqPtr[1] != 16) begin
      errCount++;
      $display("[TB] FAIL burst_other_first: grant=%b accepted=%0d want 01 16", grant_o, seqPtr[1]);
    end
    step();
    step();
    vecCount++;
    if (grant_o !== 2'b10 || seqPtr[0] != 1) begin
      errCount++;
      $display("[TB] FAIL burst_regrant: grant=%b req0_sent=%0d want 10 1", grant_o, seqPtr[0]);
    end
    vecCount++;
    if (obsQ.size() != 17 || obsQ[15] !== 8'h8F || obsQ[16] !== 8'h55) begin
      errCount++;
      $display("[TB] FAIL burst_stream: bytes=%0d want 17 ending 8f 55", obsQ.size());
    end
  endtask

  task automatic test_idle_timeout();
    do_reset();
    seqData[0][0] = 8'h5A;
    seqLen[0] = 1;
    drive_inputs();
    step();
    step();
    vecCount++;
    if (tx_data_o !== 8'h5A || grant_o !== 2'b01) begin
      errCount++;
      $display("[TB] FAIL idle_first_byte: data=%h grant=%b want 5a 01", tx_data_o, grant_o);
    end
    repeat (31) step();
    vecCount++;
    if (grant_o !== 2'b01) begin
      errCount++;
      $display("[TB] FAIL idle_hold_31: grant=%b want 01", grant_o);
    end
    step();
    vecCount++;
    if (grant_o !== 2'b00 || busy_o !== 1'b0) begin
      errCount++;
      $display("[TB] FAIL idle_release_32: grant=%b busy=%b want 00 0", grant_o, busy_o);
    end
  endtask

  task automatic test_backpressure();
    int bad = 0;
    do_reset();
    tx_ready_i = 1'b0;
    seqData[0][0] = 8'h61;
    seqData[0][1] = 8'h62;
    seqLen[0] = 2;
    drive_inputs();
    step();
    step();
    for (int c = 0; c < 100; c++) begin
      step();
      vecCount++;
      if (grant_o !== 2'b01 || tx_valid_o !== 1'b1 || tx_data_o !== 8'h61 || req_ready_o[0] !== 1'b0) begin
        errCount++;
        bad++;
        if (bad <= 3) begin
          $display("[TB] FAIL stall[%0d]: grant=%b valid=%b data=%h ready0=%b want 01 1 61 0",
                   c, grant_o, tx_valid_o, tx_data_o, req_ready_o[0]);
        end
      end
    end
    tx_ready_i = 1'b1;
    step();
    vecCount++;
    if (tx_valid_o !== 1'b1 || tx_data_o !== 8'h62 || seqPtr[0] != 2) begin
      errCount++;
      $display("[TB] FAIL stall_resume: valid=%b data=%h sent=%0d want 1 62 2", tx_valid_o, tx_data_o, seqPtr[0]);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    seqData[0][0] = 8'h41; seqData[0][1] = 8'h42; seqData[0][2] = 8'h43;
    seqLast[0][2] = 1'b1;  seqLen[0] = 3;
    seqData[1][0] = 8'h99; seqLast[1][0] = 1'b1; seqLen[1] = 1;
    drive_inputs();
    step();
    step();
    vecCount++;
    if (tx_valid_o !== 1'b1 || grant_o !== 2'b01) begin
      errCount++;
      $display("[TB] FAIL areset_setup: valid=%b grant=%b want 1 01", tx_valid_o, grant_o);
    end
    #2;
    reset_i = 1'b0;
    #1;
    vecCount++;
    if (tx_valid_o !== 1'b0 || grant_o !== 2'b00 || busy_o !== 1'b0 || req_ready_o !== 2'b00) begin
      errCount++;
      $display("[TB] FAIL areset_immediate: valid=%b grant=%b busy=%b ready=%b want 0 00 0 00",
               tx_valid_o, grant_o, busy_o, req_ready_o);
    end
    @(posedge clk);
    #1;
    reset_i = 1'b1;
    step();
    vecCount++;
    if (grant_o !== 2'b01) begin
      errCount++;
      $display("[TB] FAIL areset_rearb: grant=%b want 01", grant_o);
    end
  endtask

  task automatic test_back_to_back();
    int cyc = 0;
    do_reset();
    for (int j = 0; j < 8; j++) begin
      seqData[0][j] = 8'hC0 + 8'(j);
    end
    seqLast[0][7] = 1'b1;
    seqLen[0] = 8;
    drive_inputs();
    while (obsQ.size() < 8 && cyc < 60) begin
      tx_ready_i = (cyc % 3 != 1);
      step();
      cyc++;
    end
    tx_ready_i = 1'b1;
    repeat (3) step();
    vecCount++;
    if (obsQ.size() != 8) begin
      errCount++;
      $display("[TB] FAIL b2b_count: bytes=%0d want 8 (cycles used %0d)", obsQ.size(), cyc);
    end
    for (int j = 0; j < 8; j++) begin
      if (j < obsQ.size()) begin
        vecCount++;
        if (obsQ[j] !== 8'hC0 + 8'(j)) begin
          errCount++;
          $display("[TB] FAIL b2b_order[%0d]: byte=%h want %h", j, obsQ[j], 8'hC0 + 8'(j));
        end
      end
    end
  endtask

  initial begin
    reset_i     = 1'b0;
    tx_ready_i  = 1'b1;
    req_valid_i = '0;
    req_data_i  = '0;
    req_last_i  = '0;
    $display("[TB] starting tx_stream_arbiter tests");
    test_reset();
    test_single_packet();
    test_round_robin();
    test_max_burst();
    test_idle_timeout();
    test_backpressure();
    test_async_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
